// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side consumer for the async FIFO, in the read clock domain.
// Pops FIFO words, absorbs the one-cycle registered read latency, keeps up to
// three words in a small circular buffer and emits them as OUT_BITS-wide beats
// on a valid/ready stream.
// Optional statistics counters are enabled by defining FIFO_RD_STREAM_STATS_EN.
module fifo_rd_stream #(
  parameter int BITS      = 32,
  parameter int OUT_BITS  = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic                rd_clk,
  input  logic                rd_rst_n,
  output logic                fifo_rd_en,
  input  logic [BITS-1:0]     fifo_rd_data,
  input  logic                fifo_rd_empty,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [OUT_BITS-1:0] m_data,
  output logic                m_last_beat
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [15:0]         stat_words,
  output logic [15:0]         stat_stall
`endif
);

  localparam int RATIO  = BITS / OUT_BITS;
  localparam int BEAT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);

  logic [BITS-1:0]   r_buf [3];
  logic [1:0]        r_head;
  logic [1:0]        r_tail;
  logic [1:0]        r_occ;
  logic              r_in_flight;
  logic [BEAT_W-1:0] r_beat;

  logic              w_pop;
  logic              w_cap;
  logic              w_xfer;
  logic              w_drain;
  logic [BITS-1:0]   w_head_word;
  logic [BEAT_W-1:0] w_slice;

  // Pointers live in 0..2 and wrap modulo 3.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Request a pop only if the word plus any word already in flight still fits;
  // held low while reset is asserted.
  assign fifo_rd_en  = rd_rst_n && (({1'b0, r_occ} + {2'b00, r_in_flight}) < 3'd3);
  assign w_pop       = fifo_rd_en && !fifo_rd_empty;
  assign w_cap       = r_in_flight;

  assign m_valid     = (r_occ != 2'd0);
  assign w_xfer      = m_valid && m_ready;
  assign w_drain     = w_xfer && (r_beat == LAST_BEAT);

  assign w_head_word = r_buf[r_head];
  assign w_slice     = (LSB_FIRST != 0) ? r_beat : (LAST_BEAT - r_beat);
  assign m_data      = OUT_BITS'(w_head_word >> (w_slice * OUT_BITS));
  assign m_last_beat = m_valid && (r_beat == LAST_BEAT);

  // Word storage: the word returned by last cycle's pop lands in the tail slot.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      for (int i = 0; i < 3; i++) r_buf[i] <= '0;
    end else if (w_cap) begin
      r_buf[r_tail] <= fifo_rd_data;
    end
  end

  // Pop tracking, pointers, occupancy and beat position within the head word.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      r_in_flight <= 1'b0;
      r_head      <= 2'd0;
      r_tail      <= 2'd0;
      r_occ       <= 2'd0;
      r_beat      <= '0;
    end else begin
      r_in_flight <= w_pop;
      if (w_cap)   r_tail <= ptr_inc(r_tail);
      if (w_drain) r_head <= ptr_inc(r_head);
      if (w_xfer)  r_beat <= w_drain ? '0 : r_beat + 1'b1;
      case ({w_cap, w_drain})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

`ifdef FIFO_RD_STREAM_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Drained-word count wraps; stall-cycle count saturates.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      stat_words <= 16'd0;
      stat_stall <= 16'd0;
    end else begin
      if (w_drain)             stat_words <= stat_words + 16'd1;
      if (m_valid && !m_ready) stat_stall <= sat_inc16(stat_stall);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: three instances (32->8 LSB first,
// 32->8 MSB first, 32->32) each fed by a small behavioural FIFO read port.
module tb_fifo_rd_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_a, en_b, en_c;
  logic        v_a, v_b, v_c;
  logic        l_a, l_b, l_c;
  logic [7:0]  d_a, d_b;
  logic [31:0] d_c;
  logic [2:0]  gap;
  logic [2:0]  mr;
  logic [2:0]  empty;
  logic [2:0]  en;
  logic [31:0] rdata [3] = '{default: 32'd0};
  logic [31:0] mem [3][64];
  int          wcnt [3];
  int          rcnt [3] = '{0, 0, 0};
  int          ncomp = 0;
  int          nfail = 0;
  int          got;
  logic [7:0]  exp_a [4];
  logic [7:0]  exp_b [4];
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [15:0] sw_a, ss_a, sw_b, ss_b, sw_c, ss_c;
`endif

  always #5 clk = ~clk;

  assign en = {en_c, en_b, en_a};

  always_comb begin
    empty = '0;
    for (int k = 0; k < 3; k++) empty[k] = gap[k] || (rcnt[k] >= wcnt[k]);
  end

  // Behavioural FIFO read ports: registered data, updated only on a real pop.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (en[k] && !empty[k]) begin
        rdata[k] <= mem[k][rcnt[k]];
        rcnt[k]  <= rcnt[k] + 1;
      end
    end
  end

  fifo_rd_stream #(.BITS(32), .OUT_BITS(8), .LSB_FIRST(1)) u_a (
    .rd_clk(clk), .rd_rst_n(rst_n), .fifo_rd_en(en_a), .fifo_rd_data(rdata[0]),
    .fifo_rd_empty(empty[0]), .m_valid(v_a), .m_ready(mr[0]), .m_data(d_a),
    .m_last_beat(l_a)
`ifdef FIFO_RD_STREAM_STATS_EN
    , .stat_words(sw_a), .stat_stall(ss_a)
`endif
  );

  fifo_rd_stream #(.BITS(32), .OUT_BITS(8), .LSB_FIRST(0)) u_b (
    .rd_clk(clk), .rd_rst_n(rst_n), .fifo_rd_en(en_b), .fifo_rd_data(rdata[1]),
    .fifo_rd_empty(empty[1]), .m_valid(v_b), .m_ready(mr[1]), .m_data(d_b),
    .m_last_beat(l_b)
`ifdef FIFO_RD_STREAM_STATS_EN
    , .stat_words(sw_b), .stat_stall(ss_b)
`endif
  );

  fifo_rd_stream #(.BITS(32), .OUT_BITS(32), .LSB_FIRST(1)) u_c (
    .rd_clk(clk), .rd_rst_n(rst_n), .fifo_rd_en(en_c), .fifo_rd_data(rdata[2]),
    .fifo_rd_empty(empty[2]), .m_valid(v_c), .m_ready(mr[2]), .m_data(d_c),
    .m_last_beat(l_c)
`ifdef FIFO_RD_STREAM_STATS_EN
    , .stat_words(sw_c), .stat_stall(ss_c)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    exp_a = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    exp_b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    rst_n = 1'b1;
    gap   = 3'b000;
    mr    = 3'b111;
    mem[0][0] = 32'hA1B2C3D4;
    mem[1][0] = 32'hA1B2C3D4;
    for (int i = 0; i < 8; i++) mem[2][i] = i;
    wcnt = '{1, 1, 8};

    // Reset held with non-empty FIFOs
    #1 rst_n = 1'b0;
    #1;
    chk("rst_en_a", en_a, 0);
    chk("rst_en_c", en_c, 0);
    chk("rst_valid_a", v_a, 0);
    chk("rst_data_a", d_a, 0);
    chk("rst_data_c", d_c, 0);
    tick();
    tick();
    chk("rst_no_pop", rcnt[2], 0);
    chk("rst_last_a", l_a, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_en_a", en_a, 1);
    chk("rel_en_c", en_c, 1);

    // Single word downsized both ways; eight full-width words back to back
    tick();
    chk("lat_valid_a", v_a, 0);
    chk("lat_valid_c", v_c, 0);
    for (int c = 2; c <= 9; c++) begin
      tick();
      chk("burst_valid_c", v_c, 1);
      chk("burst_data_c", d_c, c - 2);
      chk("burst_en_c", en_c, 1);
      if (c <= 5) begin
        chk("lsb_valid", v_a, 1);
        chk("lsb_data", d_a, exp_a[c-2]);
        chk("lsb_last", l_a, (c == 5) ? 1 : 0);
        chk("msb_data", d_b, exp_b[c-2]);
        chk("msb_last", l_b, (c == 5) ? 1 : 0);
      end
    end
    tick();
    chk("burst_end_c", v_c, 0);
    chk("end_valid_a", v_a, 0);
    chk("end_valid_b", v_b, 0);

    // Ten words with the sink stalled: only three pops, head held
    mr[2] = 1'b0;
    for (int i = 0; i < 10; i++) mem[2][8+i] = 100 + i;
    wcnt[2] = 18;
    for (int q = 1; q <= 6; q++) begin
      tick();
      if (q >= 2) begin
        chk("stall_valid", v_c, 1);
        chk("stall_data", d_c, 100);
      end
      if (q >= 3) chk("stall_en", en_c, 0);
    end
    chk("stall_pops", rcnt[2], 11);
`ifdef FIFO_RD_STREAM_STATS_EN
    chk("stat_stall", ss_c, 4);
`endif
    mr[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("drain_valid", v_c, 1);
      chk("drain_data", d_c, 100 + i);
      tick();
    end
    chk("drain_end", v_c, 0);
`ifdef FIFO_RD_STREAM_STATS_EN
    chk("stat_words", sw_c, 18);
`endif

    // Empty flag toggling while pops are requested
    for (int i = 0; i < 6; i++) mem[2][18+i] = 200 + i;
    wcnt[2] = 24;
    got = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      gap[2] = (cyc < 40) ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      if (v_c) begin
        chk("gap_data", d_c, 200 + got);
        got++;
      end
    end
    chk("gap_count", got, 6);
    gap = 3'b000;

    // Reset mid-stream with two words buffered and one in flight
    mr[0] = 1'b0;
    mem[0][1] = 32'h11111111;
    mem[0][2] = 32'h22222222;
    mem[0][3] = 32'h33333333;
    wcnt[0] = 4;
    tick();
    tick();
    tick();
    chk("mid_valid", v_a, 1);
    chk("mid_data", d_a, 8'h11);
    chk("mid_en", en_a, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", v_a, 0);
    chk("async_en", en_a, 0);
    chk("async_data", d_a, 0);
    tick();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_idle", v_a, 0);
    end
    chk("post_rst_pops", rcnt[0], 4);
    mr[0] = 1'b1;
    mem[0][4] = 32'h5A6B7C8D;
    wcnt[0] = 5;
    tick();
    chk("new_lat", v_a, 0);
    tick();
    chk("new_valid", v_a, 1);
    chk("new_b0", d_a, 8'h8D);
    tick();
    chk("new_b1", d_a, 8'h7C);
    tick();
    chk("new_b2", d_a, 8'h6B);
    chk("new_b2_last", l_a, 0);
    tick();
    chk("new_b3", d_a, 8'h5A);
    chk("new_b3_last", l_a, 1);
    tick();
    chk("new_end", v_a, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
